// File: rtl/vq_window_ctrl.sv
// Measurement-window sequencer for the min/max peak tracker: clear, settle, acquire, latch, compute, publish.
// Optional VQ_AVG4_EN: res_amp/res_volt become the running mean of the last 4 windows.
module vq_window_ctrl #(
  parameter int DW         = 12,
  parameter int CW         = 31,
  parameter int WIN_LEN    = 1_000_000,
  parameter int SETTLE_LEN = 16,
  parameter int OFFSET     = 2050
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          cont,
  input  logic          abort,
  output logic          trk_clr,
  output logic          trk_en,
  input  logic [DW-1:0] trk_min,
  input  logic [DW-1:0] trk_max,
  output logic          res_vld,
  input  logic          res_rdy,
  output logic [DW-1:0] res_min,
  output logic [DW-1:0] res_max,
  output logic [DW-1:0] res_amp,
  output logic [DW-1:0] res_volt,
  output logic          busy
);

  typedef enum logic [2:0] {IDLE, CLR, SETTLE, ACQ, LATCH, CALC, PUBLISH} state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [DW-1:0] min_reg, max_reg, amp_reg, volt_reg;
  logic [DW-1:0] amp_cur, volt_cur, amp_out, volt_out;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    if (abort) begin
      state_next = IDLE;
      cnt_next   = '0;
    end else begin
      case (state_reg)
        IDLE:    if (start) state_next = CLR;
        CLR: begin
          state_next = SETTLE;
          cnt_next   = CW'(SETTLE_LEN);
        end
        SETTLE: begin
          if (cnt_reg == CW'(1)) begin
            state_next = ACQ;
            cnt_next   = CW'(WIN_LEN);
          end else begin
            cnt_next = cnt_reg - CW'(1);
          end
        end
        ACQ: begin
          if (cnt_reg == CW'(1)) begin
            state_next = LATCH;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg - CW'(1);
          end
        end
        LATCH:   state_next = CALC;
        CALC:    state_next = PUBLISH;
        PUBLISH: if (res_rdy) state_next = cont ? CLR : IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Control outputs decode the registered state, so they are glitch-free and drop one cycle after abort.
  assign trk_clr = (state_reg == CLR);
  assign trk_en  = (state_reg == ACQ);
  assign res_vld = (state_reg == PUBLISH);
  assign busy    = (state_reg != IDLE);

  assign amp_cur  = (max_reg >= min_reg) ? (max_reg - min_reg) : '0;
  assign volt_cur = (max_reg > DW'(OFFSET)) ? ((max_reg - DW'(OFFSET)) >> 1) : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      min_reg  <= '0;
      max_reg  <= '0;
      amp_reg  <= '0;
      volt_reg <= '0;
    end else if (!abort) begin
      if (state_reg == LATCH) begin
        min_reg <= trk_min;
        max_reg <= trk_max;
      end
      if (state_reg == CALC) begin
        amp_reg  <= amp_out;
        volt_reg <= volt_out;
      end
    end
  end

`ifdef VQ_AVG4_EN
  // Three previous windows plus the current one; cleared entries read as zero so the sum needs no masking.
  logic [DW-1:0] hist_amp_reg  [3];
  logic [DW-1:0] hist_volt_reg [3];
  logic [1:0]    done_reg;
  logic          hist_clr;
  logic [DW+1:0] sum_amp, sum_volt;

  assign hist_clr = abort || (state_reg == IDLE && start);

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_hist
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          hist_amp_reg[gi]  <= '0;
          hist_volt_reg[gi] <= '0;
        end else if (hist_clr) begin
          hist_amp_reg[gi]  <= '0;
          hist_volt_reg[gi] <= '0;
        end else if (state_reg == CALC) begin
          hist_amp_reg[gi]  <= (gi == 0) ? amp_cur  : hist_amp_reg[(gi == 0) ? 0 : gi-1];
          hist_volt_reg[gi] <= (gi == 0) ? volt_cur : hist_volt_reg[(gi == 0) ? 0 : gi-1];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                      done_reg <= '0;
    else if (hist_clr)                             done_reg <= '0;
    else if (state_reg == CALC && done_reg != 2'd3) done_reg <= done_reg + 2'd1;
  end

  assign sum_amp  = {2'b00, amp_cur} + {2'b00, hist_amp_reg[0]}
                  + {2'b00, hist_amp_reg[1]} + {2'b00, hist_amp_reg[2]};
  assign sum_volt = {2'b00, volt_cur} + {2'b00, hist_volt_reg[0]}
                  + {2'b00, hist_volt_reg[1]} + {2'b00, hist_volt_reg[2]};

  function automatic logic [DW-1:0] mean(input logic [DW+1:0] sum, input logic [1:0] n_prev);
    logic [DW+1:0] q;
    case (n_prev)
      2'd0:    q = sum;
      2'd1:    q = sum >> 1;
      2'd2:    q = sum / (DW+2)'(3);
      default: q = sum >> 2;
    endcase
    return q[DW-1:0];
  endfunction

  assign amp_out  = mean(sum_amp, done_reg);
  assign volt_out = mean(sum_volt, done_reg);
`else
  assign amp_out  = amp_cur;
  assign volt_out = volt_cur;
`endif

  assign res_min  = min_reg;
  assign res_max  = max_reg;
  assign res_amp  = amp_reg;
  assign res_volt = volt_reg;

endmodule

// File: tb/tb_vq_window_ctrl.sv
// Bench for vq_window_ctrl: vector table of single windows plus backpressure, abort, reset and continuous-run sequences.
module tb_vq_window_ctrl;
  localparam int DW = 12;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0, cont = 1'b0, abort = 1'b0, res_rdy = 1'b0;
  logic [DW-1:0] trk_min = '0, trk_max = '0;
  logic          trk_clr, trk_en, res_vld, busy;
  logic [DW-1:0] res_min, res_max, res_amp, res_volt;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [DW-1:0] mn;
    logic [DW-1:0] mx;
    logic [DW-1:0] amp;
    logic [DW-1:0] volt;
  } rec_t;

  rec_t sb[$];

  always #5 clk = ~clk;

  vq_window_ctrl #(.DW(DW), .CW(31), .WIN_LEN(8), .SETTLE_LEN(2), .OFFSET(2050)) dut (
    .clk(clk), .rst(rst), .start(start), .cont(cont), .abort(abort),
    .trk_clr(trk_clr), .trk_en(trk_en), .trk_min(trk_min), .trk_max(trk_max),
    .res_vld(res_vld), .res_rdy(res_rdy), .res_min(res_min), .res_max(res_max),
    .res_amp(res_amp), .res_volt(res_volt), .busy(busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  // Scoreboard: every accepted result is compared against the oldest expectation.
  always @(negedge clk) begin
    rec_t e;
    if (res_vld && res_rdy) begin
      if (sb.size() == 0) begin
        check("unexpected_result", 1, 0);
      end else begin
        e = sb.pop_front();
        check("res_min", res_min, e.mn);
        check("res_max", res_max, e.mx);
        check("res_amp", res_amp, e.amp);
        check("res_volt", res_volt, e.volt);
      end
    end
  end

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  // Counts cycles from the sampling edge of start (or of a trk_clr cycle) until res_vld is seen.
  task automatic wait_vld(output int lat, output int n_clr, output int n_en);
    lat = 0; n_clr = 0; n_en = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (trk_clr) n_clr++;
      if (trk_en)  n_en++;
      if (res_vld) return;
      lat++;
    end
    check("vld_timeout", 0, 1);
    lat = -1;
  endtask

  task automatic no_vld_for(input string name, input int n);
    int seen;
    seen = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (res_vld || busy) seen++;
    end
    check(name, seen, 0);
  endtask

  rec_t tbl[6];
`ifdef VQ_AVG4_EN
  int cont_amp[4]  = '{2052, 2053, 2054, 2055};
  int cont_volt[4] = '{1, 1, 2, 2};
`else
  int cont_amp[4]  = '{2052, 2054, 2056, 2058};
  int cont_volt[4] = '{1, 2, 3, 4};
`endif

  initial begin
    int lat, nc, ne;
    tbl[0] = '{100,  3000, 2900, 475};
    tbl[1] = '{1200, 1000, 0,    0};
    tbl[2] = '{0,    4095, 4095, 1022};
    tbl[3] = '{0,    2051, 2051, 0};
    tbl[4] = '{7,    7,    0,    0};
    tbl[5] = '{2000, 2060, 60,   5};

    // Reset state
    @(negedge clk);
    check("rst_outs", {busy, trk_clr, trk_en, res_vld}, 0);
    check("rst_res", {res_min, res_max}, 0);
    @(posedge clk); #1 rst = 1'b1;

    // Single windows from IDLE; each start clears any averaging history
    res_rdy = 1'b1;
    foreach (tbl[i]) begin
      trk_min = tbl[i].mn;
      trk_max = tbl[i].mx;
      sb.push_back('{tbl[i].mn, tbl[i].mx, tbl[i].amp, tbl[i].volt});
      pulse_start();
      wait_vld(lat, nc, ne);
      check("latency", lat, 13);
      check("clr_cycles", nc, 1);
      check("en_cycles", ne, 8);
      @(negedge clk);
      check("idle_after_hs", {busy, res_vld}, 0);
    end

    // Backpressure: result and state held while res_rdy is low
    res_rdy = 1'b0;
    trk_min = 500; trk_max = 2500;
    sb.push_back('{12'd500, 12'd2500, 12'd2000, 12'd225});
    pulse_start();
    wait_vld(lat, nc, ne);
    check("bp_latency", lat, 13);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("bp_hold", {res_vld, busy, trk_clr, 4'h0, res_amp, res_volt},
            {1'b1, 1'b1, 1'b0, 4'h0, 12'd2000, 12'd225});
    end
    @(posedge clk); #1 res_rdy = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("vld_falls", res_vld, 0);

    // Abort during ACQ, then start+abort together in IDLE
    trk_min = 100; trk_max = 3000;
    pulse_start();
    repeat (5) @(posedge clk);
    #1 check("in_acq", trk_en, 1);
    abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    check("abort_idle", {busy, trk_en, trk_clr, res_vld}, 0);
    check("abort_keeps_res", {res_min, res_amp}, {12'd500, 12'd2000});
    @(posedge clk); #1 start = 1'b1; abort = 1'b1;
    @(posedge clk); #1 start = 1'b0; abort = 1'b0;
    no_vld_for("abort_start_ignored", 20);

    // Async reset mid-window: immediate clear, no result
    pulse_start();
    repeat (5) @(posedge clk);
    #2 rst = 1'b0;
    #1 check("arst_clear", {busy, trk_en, res_vld}, 0);
    check("arst_res", {res_min, res_amp}, 0);
    @(posedge clk); #1 rst = 1'b1;
    no_vld_for("arst_no_result", 20);

    // Continuous run of 4 windows; cont dropped during the last one
    cont = 1'b1;
    trk_min = 0; trk_max = 2052;
    for (int w = 0; w < 4; w++)
      sb.push_back('{12'd0, 12'(2052 + 2*w), 12'(cont_amp[w]), 12'(cont_volt[w])});
    pulse_start();
    for (int w = 0; w < 4; w++) begin
      wait_vld(lat, nc, ne);
      check("cont_latency", lat, 13);
      if (w < 3) begin
        @(posedge clk); #1;
        check("clr_after_hs", trk_clr, 1);
        trk_max = 12'(2054 + 2*w);
        if (w == 2) cont = 1'b0;
      end
    end
    @(negedge clk);
    check("cont_stop_idle", {busy, res_vld}, 0);
    no_vld_for("cont_no_extra", 20);

    check("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

endmodule
